// File: rtl/pid_multi_axis.sv
// pid_multi_axis: time-multiplexed PID controller for N_AXES channels.
// A single signed GAIN_W x (DATA_W+4) multiplier is shared by the P, I and D
// terms of every axis; each axis takes five cycles (ERR, P, I, D, SUM).
// Optional feature macro: PID_ANTIWINDUP_EN (freezes a saturated integrator
// that would keep pushing the output further into saturation).
// Handshake: start is a request sampled only while idle (busy=0) and is dropped,
// not queued, otherwise; out_valid is a one-cycle strobe marking the cycle in
// which pid_out/sat_flags present new values, which then hold until the next one.
module pid_multi_axis #(
  parameter int N_AXES    = 3,
  parameter int DATA_W    = 16,
  parameter int GAIN_W    = 16,
  parameter int FRAC_W    = 8,
  parameter int OUT_W     = 16,
  parameter int INT_LIMIT = 4096
) (
  input  logic                     sys_clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic                     clear_integ,
  input  logic [N_AXES*DATA_W-1:0] setpoint,
  input  logic [N_AXES*DATA_W-1:0] measured,
  input  logic [N_AXES*GAIN_W-1:0] kp,
  input  logic [N_AXES*GAIN_W-1:0] ki,
  input  logic [N_AXES*GAIN_W-1:0] kd,
  output logic                     busy,
  output logic                     out_valid,
  output logic [N_AXES*OUT_W-1:0]  pid_out,
  output logic [N_AXES-1:0]        sat_flags,
  output logic [2:0]               fsm_state
);

  localparam int OP_W   = DATA_W + 4;
  localparam int PROD_W = GAIN_W + OP_W;
  localparam int ACC_W  = PROD_W + 2;
  localparam int AXW    = (N_AXES > 1) ? $clog2(N_AXES) : 1;

  localparam logic signed [OP_W-1:0]  LIM_P   = OP_W'(INT_LIMIT);
  localparam logic signed [OP_W-1:0]  LIM_N   = -LIM_P;
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ERR  = 3'd1,
    S_P    = 3'd2,
    S_I    = 3'd3,
    S_D    = 3'd4,
    S_SUM  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t state_q, state_d;

  logic [AXW-1:0]           axis_q;
  logic                     last_axis;
  int                       ax;

  logic [N_AXES*DATA_W-1:0] sp_q, meas_q;
  logic [N_AXES*GAIN_W-1:0] kp_q, ki_q, kd_q;

  logic signed [OP_W-1:0]   integ_q [N_AXES];
  logic signed [DATA_W:0]   eprev_q [N_AXES];
  logic signed [DATA_W:0]   e_q;
  logic signed [PROD_W-1:0] p_q, i_q, d_q;
  logic                     pending_q;
  logic [N_AXES*OUT_W-1:0]  stage_q;
  logic [N_AXES-1:0]        stage_sat_q;

  logic signed [DATA_W-1:0] sp_ax, meas_ax;
  logic signed [DATA_W:0]   err_new;
  logic signed [OP_W-1:0]   e_ext, integ_sum, integ_next, diff;
  logic                     hold;
  logic signed [GAIN_W-1:0] mul_g;
  logic signed [OP_W-1:0]   mul_b;
  logic signed [PROD_W-1:0] prod, term;
  logic signed [ACC_W-1:0]  sum;
  logic [OUT_W-1:0]         clip_val;
  logic                     clipped;
  logic [N_AXES*OUT_W-1:0]  stage_next;
  logic [N_AXES-1:0]        stage_sat_next;

  assign ax        = int'(axis_q);
  assign last_axis = (axis_q == AXW'(N_AXES - 1));

  // State register.
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state: five states per axis, then a single DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ERR;
      S_ERR:   state_d = S_P;
      S_P:     state_d = S_I;
      S_I:     state_d = S_D;
      S_D:     state_d = S_SUM;
      S_SUM:   state_d = last_axis ? S_DONE : S_ERR;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_DONE);
    fsm_state = state_q;
  end

  // Per-axis operand selection and error / integrator arithmetic.
  always_comb begin
    sp_ax      = sp_q[ax*DATA_W +: DATA_W];
    meas_ax    = meas_q[ax*DATA_W +: DATA_W];
    err_new    = {sp_ax[DATA_W-1], sp_ax} - {meas_ax[DATA_W-1], meas_ax};
    e_ext      = {{3{e_q[DATA_W]}}, e_q};
    diff       = e_ext - {{3{eprev_q[ax][DATA_W]}}, eprev_q[ax]};
    integ_sum  = integ_q[ax] + e_ext;
`ifdef PID_ANTIWINDUP_EN
    hold       = sat_flags[ax] && (e_q[DATA_W] == pid_out[ax*OUT_W + OUT_W - 1]);
`else
    hold       = 1'b0;
`endif
    if (hold)                  integ_next = integ_q[ax];
    else if (integ_sum > LIM_P) integ_next = LIM_P;
    else if (integ_sum < LIM_N) integ_next = LIM_N;
    else                       integ_next = integ_sum;
  end

  // Shared multiplier input mux: one gain and one operand per state.
  always_comb begin
    mul_g = '0;
    mul_b = '0;
    case (state_q)
      S_P: begin mul_g = kp_q[ax*GAIN_W +: GAIN_W]; mul_b = e_ext;      end
      S_I: begin mul_g = ki_q[ax*GAIN_W +: GAIN_W]; mul_b = integ_next; end
      S_D: begin mul_g = kd_q[ax*GAIN_W +: GAIN_W]; mul_b = diff;       end
      default: ;
    endcase
  end

  assign prod = $signed({{OP_W{mul_g[GAIN_W-1]}}, mul_g}) * $signed({{GAIN_W{mul_b[OP_W-1]}}, mul_b});
  assign term = prod >>> FRAC_W;

  // Full-width sum of the three terms, clipped to the output range.
  always_comb begin
    sum = $signed({{2{p_q[PROD_W-1]}}, p_q}) + $signed({{2{i_q[PROD_W-1]}}, i_q})
        + $signed({{2{d_q[PROD_W-1]}}, d_q});
    if (sum > OUT_MAX) begin
      clip_val = OUT_MAX[OUT_W-1:0];
      clipped  = 1'b1;
    end else if (sum < OUT_MIN) begin
      clip_val = OUT_MIN[OUT_W-1:0];
      clipped  = 1'b1;
    end else begin
      clip_val = sum[OUT_W-1:0];
      clipped  = 1'b0;
    end
    stage_next         = stage_q;
    stage_sat_next     = stage_sat_q;
    stage_next[ax*OUT_W +: OUT_W] = clip_val;
    stage_sat_next[ax] = clipped;
  end

  // Datapath registers, per-axis state and deferred integrator clearing.
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      axis_q      <= '0;
      sp_q        <= '0;
      meas_q      <= '0;
      kp_q        <= '0;
      ki_q        <= '0;
      kd_q        <= '0;
      e_q         <= '0;
      p_q         <= '0;
      i_q         <= '0;
      d_q         <= '0;
      pending_q   <= 1'b0;
      stage_q     <= '0;
      stage_sat_q <= '0;
      pid_out     <= '0;
      sat_flags   <= '0;
      for (int a = 0; a < N_AXES; a++) begin
        integ_q[a] <= '0;
        eprev_q[a] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          sp_q   <= setpoint;
          meas_q <= measured;
          kp_q   <= kp;
          ki_q   <= ki;
          kd_q   <= kd;
          axis_q <= '0;
        end
        S_ERR: e_q <= err_new;
        S_P:   p_q <= term;
        S_I: begin
          i_q         <= term;
          integ_q[ax] <= integ_next;
        end
        S_D: begin
          d_q         <= term;
          eprev_q[ax] <= e_q;
        end
        S_SUM: begin
          stage_q     <= stage_next;
          stage_sat_q <= stage_sat_next;
          if (last_axis) begin
            pid_out   <= stage_next;
            sat_flags <= stage_sat_next;
            axis_q    <= '0;
          end else begin
            axis_q    <= axis_q + 1'b1;
          end
        end
        default: ;
      endcase
      // Clears land only where no pass is mid-flight: idle, or after the last SUM.
      if ((state_q == S_IDLE) || (state_q == S_DONE)) begin
        pending_q <= 1'b0;
        if (pending_q || clear_integ) begin
          for (int a = 0; a < N_AXES; a++) begin
            integ_q[a] <= '0;
            eprev_q[a] <= '0;
          end
        end
      end else begin
        pending_q <= pending_q | clear_integ;
      end
    end
  end

endmodule

// File: tb/tb_pid_multi_axis.sv
// Self-checking bench for pid_multi_axis with a behavioural per-axis PID model.
module tb_pid_multi_axis;
  localparam int N   = 3;
  localparam int DW  = 16;
  localparam int GW  = 16;
  localparam int FW  = 8;
  localparam int OW  = 16;
  localparam int LIM = 4096;
  localparam int PASS_CYC = 5 * N + 1;

  logic            sys_clk = 1'b0;
  logic            resetn = 1'b0;
  logic            start = 1'b0;
  logic            clear_integ = 1'b0;
  logic [N*DW-1:0] setpoint = '0;
  logic [N*DW-1:0] measured = '0;
  logic [N*GW-1:0] kp = '0;
  logic [N*GW-1:0] ki = '0;
  logic [N*GW-1:0] kd = '0;
  logic            busy, out_valid;
  logic [N*OW-1:0] pid_out;
  logic [N-1:0]    sat_flags;
  logic [2:0]      fsm_state;

  pid_multi_axis dut (
    .sys_clk(sys_clk), .resetn(resetn), .start(start), .clear_integ(clear_integ),
    .setpoint(setpoint), .measured(measured), .kp(kp), .ki(ki), .kd(kd),
    .busy(busy), .out_valid(out_valid), .pid_out(pid_out), .sat_flags(sat_flags),
    .fsm_state(fsm_state)
  );

  // Clock / reset
  always #5 sys_clk = ~sys_clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model state
  longint m_sp[N], m_meas[N], m_kp[N], m_ki[N], m_kd[N];
  longint m_integ[N], m_eprev[N], m_out[N];
  bit     m_sat[N];

  // Scoreboard
  logic [N*OW-1:0] exp_q[$];
  logic [N*OW-1:0] cap_out;
  logic [N-1:0]    cap_sat;

  function automatic longint rnd_s16();
    logic signed [15:0] t;
    t = 16'($urandom);
    return longint'(t);
  endfunction

  function automatic logic [N*OW-1:0] pack_out();
    logic [N*OW-1:0] v;
    v = '0;
    for (int a = 0; a < N; a++) v[a*OW +: OW] = OW'(m_out[a]);
    return v;
  endfunction

  function automatic logic [N-1:0] pack_sat();
    logic [N-1:0] v;
    for (int a = 0; a < N; a++) v[a] = m_sat[a];
    return v;
  endfunction

  function automatic longint out_axis(int a);
    logic signed [OW-1:0] t;
    t = cap_out[a*OW +: OW];
    return longint'(t);
  endfunction

  // One pass of the PID law over every axis, straight from the arithmetic rules.
  task automatic model_pass();
    for (int a = 0; a < N; a++) begin
      longint e, p, i, d, s, ni;
      bit hold;
      e = m_sp[a] - m_meas[a];
      p = (m_kp[a] * e) >>> FW;
      hold = 1'b0;
`ifdef PID_ANTIWINDUP_EN
      hold = m_sat[a] && ((e < 0) == (m_out[a] < 0));
`endif
      if (!hold) begin
        ni = m_integ[a] + e;
        if (ni > LIM) ni = LIM;
        if (ni < -LIM) ni = -LIM;
        m_integ[a] = ni;
      end
      i = (m_ki[a] * m_integ[a]) >>> FW;
      d = (m_kd[a] * (e - m_eprev[a])) >>> FW;
      m_eprev[a] = e;
      s = p + i + d;
      m_sat[a] = 1'b0;
      if (s > 32767)  begin s = 32767;  m_sat[a] = 1'b1; end
      if (s < -32768) begin s = -32768; m_sat[a] = 1'b1; end
      m_out[a] = s;
    end
  endtask

  task automatic model_clear();
    for (int a = 0; a < N; a++) begin m_integ[a] = 0; m_eprev[a] = 0; end
  endtask

  task automatic model_reset();
    model_clear();
    for (int a = 0; a < N; a++) begin m_out[a] = 0; m_sat[a] = 1'b0; end
  endtask

  // Driver tasks
  task automatic drive_all();
    for (int a = 0; a < N; a++) begin
      setpoint[a*DW +: DW] = DW'(m_sp[a]);
      measured[a*DW +: DW] = DW'(m_meas[a]);
      kp[a*GW +: GW]       = GW'(m_kp[a]);
      ki[a*GW +: GW]       = GW'(m_ki[a]);
      kd[a*GW +: GW]       = GW'(m_kd[a]);
    end
  endtask

  task automatic set_axis(input int a, input longint sp, input longint meas,
                          input longint kp_v, input longint ki_v, input longint kd_v);
    m_sp[a] = sp; m_meas[a] = meas; m_kp[a] = kp_v; m_ki[a] = ki_v; m_kd[a] = kd_v;
    drive_all();
  endtask

  task automatic zero_all();
    for (int a = 0; a < N; a++) set_axis(a, 0, 0, 0, 0, 0);
  endtask

  task automatic randomize_axes();
    for (int a = 0; a < N; a++) begin
      m_sp[a] = rnd_s16(); m_meas[a] = rnd_s16();
      m_kp[a] = rnd_s16(); m_ki[a] = rnd_s16(); m_kd[a] = rnd_s16();
    end
    drive_all();
  endtask

  task automatic scramble_ports();
    setpoint = {N{16'($urandom)}};
    measured = {N{16'($urandom)}};
    kp = {N{16'($urandom)}};
    ki = {N{16'($urandom)}};
    kd = {N{16'($urandom)}};
  endtask

  task automatic clear_idle();
    clear_integ = 1'b1;
    @(posedge sys_clk); #1;
    clear_integ = 1'b0;
    @(posedge sys_clk); #1;
    model_clear();
  endtask

  // One pass, watched for 40 cycles: latency, busy length, held outputs, results.
  task automatic run_pass(input int mid_start_at, input bit mid_clear,
                          input bit clear_with_start, input bit scramble);
    logic [N*OW-1:0] exp_old, exp_tmp;
    logic [N-1:0]    exp_sat;
    int busy_cnt, valid_cnt, valid_at;
    bit held_ok;
    exp_old = pack_out();
    drive_all();
    clear_integ = clear_with_start;
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    clear_integ = 1'b0;
    if (clear_with_start) model_clear();
    model_pass();
    exp_sat = pack_sat();
    exp_q.push_back(pack_out());
    if (mid_clear) model_clear();
    busy_cnt = 0; valid_cnt = 0; valid_at = 0; held_ok = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      if (busy) busy_cnt++;
      if (out_valid) begin
        valid_cnt++;
        valid_at = n;
        cap_out = pid_out;
        cap_sat = sat_flags;
        vec_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++;
          $display("FAIL spurious_out_valid: got out_valid=1 at cycle %0d required no pending result", n);
        end else begin
          exp_tmp = exp_q.pop_front();
          if (pid_out !== exp_tmp) begin
            err_cnt++;
            $display("FAIL pid_out: got %h required %h", pid_out, exp_tmp);
          end
        end
        vec_cnt++;
        if (sat_flags !== exp_sat) begin
          err_cnt++;
          $display("FAIL sat_flags: got %b required %b", sat_flags, exp_sat);
        end
      end else if (valid_cnt == 0 && pid_out !== exp_old) begin
        held_ok = 1'b0;
      end
      start = (n == mid_start_at);
      clear_integ = (mid_clear && n == 3);
      if (scramble && busy) scramble_ports();
      @(posedge sys_clk); #1;
    end
    start = 1'b0;
    clear_integ = 1'b0;
    exp_q.delete();
    drive_all();
    vec_cnt++;
    if (valid_cnt != 1) begin
      err_cnt++;
      $display("FAIL valid_count: got %0d required 1", valid_cnt);
    end
    vec_cnt++;
    if (valid_at != PASS_CYC) begin
      err_cnt++;
      $display("FAIL valid_latency: got %0d required %0d", valid_at, PASS_CYC);
    end
    vec_cnt++;
    if (busy_cnt != PASS_CYC) begin
      err_cnt++;
      $display("FAIL busy_cycles: got %0d required %0d", busy_cnt, PASS_CYC);
    end
    vec_cnt++;
    if (!held_ok) begin
      err_cnt++;
      $display("FAIL pid_out_held: got early change required %h until out_valid", exp_old);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #3;
    vec_cnt++;
    if ({busy, out_valid, pid_out, sat_flags} !== '0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got busy=%b valid=%b out=%h sat=%b required all 0",
               busy, out_valid, pid_out, sat_flags);
    end
    model_reset();
    zero_all();
    @(posedge sys_clk); #1;
    resetn = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    vec_cnt++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL idle_after_reset: got busy=%b valid=%b required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_proportional();
    zero_all();
    clear_idle();
    set_axis(0, 100, 40, 16'h0100, 0, 0);
    run_pass(0, 0, 0, 0);
    vec_cnt++;
    if (out_axis(0) != 60 || cap_sat !== 3'b000) begin
      err_cnt++;
      $display("FAIL p_term: got %0d sat=%b required 60 sat=000", out_axis(0), cap_sat);
    end
  endtask

  task automatic test_integral();
    zero_all();
    clear_idle();
    set_axis(1, 10, 0, 0, 16'h0080, 0);
    for (int k = 1; k <= 3; k++) begin
      run_pass(0, 0, 0, 0);
      vec_cnt++;
      if (out_axis(1) != 5 * k) begin
        err_cnt++;
        $display("FAIL i_term_pass%0d: got %0d required %0d", k, out_axis(1), 5 * k);
      end
    end
    clear_idle();
    run_pass(0, 0, 0, 0);
    vec_cnt++;
    if (out_axis(1) != 5) begin
      err_cnt++;
      $display("FAIL i_after_clear: got %0d required 5", out_axis(1));
    end
  endtask

  task automatic test_derivative();
    zero_all();
    clear_idle();
    set_axis(2, 10, 0, 0, 0, 16'h0100);
    run_pass(0, 0, 0, 0);
    vec_cnt++;
    if (out_axis(2) != 10) begin
      err_cnt++;
      $display("FAIL d_first: got %0d required 10", out_axis(2));
    end
    set_axis(2, 30, 0, 0, 0, 16'h0100);
    run_pass(0, 0, 0, 0);
    vec_cnt++;
    if (out_axis(2) != 20) begin
      err_cnt++;
      $display("FAIL d_second: got %0d required 20", out_axis(2));
    end
  endtask

  task automatic test_saturation();
    zero_all();
    clear_idle();
    set_axis(0, 1000, 0, 16'h7FFF, 0, 0);
    run_pass(0, 0, 0, 0);
    vec_cnt++;
    if (out_axis(0) != 32767 || cap_sat[0] !== 1'b1) begin
      err_cnt++;
      $display("FAIL sat_pos: got %0d flag=%b required 32767 flag=1", out_axis(0), cap_sat[0]);
    end
    set_axis(0, -1000, 0, 16'h7FFF, 0, 0);
    run_pass(0, 0, 0, 0);
    vec_cnt++;
    if (out_axis(0) != -32768 || cap_sat[0] !== 1'b1) begin
      err_cnt++;
      $display("FAIL sat_neg: got %0d flag=%b required -32768 flag=1", out_axis(0), cap_sat[0]);
    end
  endtask

  task automatic test_integ_clamp();
    longint exp_i[6];
    exp_i = '{1000, 2000, 3000, 4000, 4096, 4096};
    zero_all();
    clear_idle();
    set_axis(0, 1000, 0, 0, 16'h0100, 0);
    for (int k = 0; k < 6; k++) begin
      run_pass(0, 0, 0, 0);
      vec_cnt++;
      if (out_axis(0) != exp_i[k]) begin
        err_cnt++;
        $display("FAIL integ_clamp_pass%0d: got %0d required %0d", k, out_axis(0), exp_i[k]);
      end
    end
  endtask

  task automatic test_antiwindup();
    zero_all();
    clear_idle();
    set_axis(0, 1000, 0, 16'h7FFF, 16'h0100, 0);
    repeat (4) run_pass(0, 0, 0, 0);
    set_axis(0, -300, 0, 16'h0100, 16'h0100, 0);
    repeat (3) run_pass(0, 0, 0, 0);
  endtask

  task automatic test_clear_timing();
    zero_all();
    clear_idle();
    for (int a = 0; a < N; a++) set_axis(a, 200 * (a + 1), 0, 0, 16'h0100, 16'h0040);
    run_pass(0, 0, 0, 0);
    run_pass(0, 1, 0, 0);
    run_pass(0, 0, 0, 0);
    run_pass(0, 0, 1, 0);
  endtask

  task automatic test_back_to_back();
    randomize_axes();
    run_pass(5, 0, 0, 1);
    run_pass(PASS_CYC - 1, 0, 0, 1);
  endtask

  task automatic test_reset_mid_pass();
    int spurious;
    randomize_axes();
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    repeat (6) @(posedge sys_clk);
    #1;
    resetn = 1'b0;
    #1;
    vec_cnt++;
    if ({busy, out_valid, pid_out, sat_flags} !== '0) begin
      err_cnt++;
      $display("FAIL midpass_reset: got busy=%b valid=%b out=%h sat=%b required all 0",
               busy, out_valid, pid_out, sat_flags);
    end
    model_reset();
    @(posedge sys_clk); #1;
    resetn = 1'b1;
    spurious = 0;
    repeat (20) begin
      @(posedge sys_clk); #1;
      if (out_valid) spurious++;
    end
    vec_cnt++;
    if (spurious != 0) begin
      err_cnt++;
      $display("FAIL abandoned_pass: got %0d out_valid pulses required 0", spurious);
    end
    run_pass(0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 15; k++) begin
      randomize_axes();
      run_pass(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, PASS_CYC - 1)) : 0,
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_proportional();
    test_integral();
    test_derivative();
    test_saturation();
    test_integ_clamp();
    test_antiwindup();
    test_clear_timing();
    test_back_to_back();
    test_reset_mid_pass();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
